// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - segment bus and decoded-value bundle for seg_scan_decoder
interface seg_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [7:0]          seg_data;
  logic [DIGITS-1:0]   seg_com;
  logic                clr;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   dp_flags;
  logic [DIGITS-1:0]   digit_valid;
  logic                frame_done;
  logic                err;
  logic                err_sticky;

  modport master (
    output seg_data, seg_com, clr,
    input  digits, dp_flags, digit_valid, frame_done, err, err_sticky
  );

  modport slave (
    input  seg_data, seg_com, clr,
    output digits, dp_flags, digit_valid, frame_done, err, err_sticky
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers per-digit binary values from a multiplexed active-low 7-segment bus
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  seg_scan_decoder_if.slave bus
);
  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]        CNT_FIRE = 8'(STABLE_CYCLES - 2);
  localparam logic [DIGITS-1:0] ALL_SEEN = {DIGITS{1'b1}};

  logic [7:0]             r_data_s1, r_data_s2, r_prev_data;
  logic [DIGITS-1:0]      r_com_s1, r_com_s2, r_prev_com;
  logic [7:0]             r_cnt;
  logic [DIGITS-1:0][3:0] r_digits;
  logic [DIGITS-1:0]      r_dp, r_valid, r_mask;
  logic                   r_frame_done, r_err, r_err_sticky;

  logic                   w_same, w_capture, w_idle, w_onehot;
  logic                   w_known, w_blank;
  logic [3:0]             w_val;
  logic [DIGITS-1:0]      w_low, w_mask_next;
  logic [IDX_W-1:0]       w_idx;

  assign w_same      = ({r_com_s2, r_data_s2} == {r_prev_com, r_prev_data});
  // Fires on the transition into STABLE_CYCLES-1, so each stable pattern is captured once.
  assign w_capture   = w_same && (r_cnt == CNT_FIRE);
  assign w_low       = ~r_com_s2;
  assign w_idle      = (w_low == '0);
  assign w_onehot    = !w_idle && ((w_low & (w_low - DIGITS'(1))) == '0);
  assign w_blank     = (r_data_s2[7:1] == 7'b1111111);
  assign w_mask_next = r_mask | (DIGITS'(1) << w_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_s1   <= '1;
      r_data_s2   <= '1;
      r_com_s1    <= '1;
      r_com_s2    <= '1;
      r_prev_data <= '1;
      r_prev_com  <= '1;
      r_cnt       <= '0;
    end else begin
      r_data_s1   <= bus.seg_data;
      r_data_s2   <= r_data_s1;
      r_com_s1    <= bus.seg_com;
      r_com_s2    <= r_com_s1;
      r_prev_data <= r_data_s2;
      r_prev_com  <= r_com_s2;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_low[i]) w_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_val   = 4'd0;
    w_known = 1'b1;
    case (r_data_s2[7:1])
      7'b0000001: w_val = 4'd0;
      7'b1001111: w_val = 4'd1;
      7'b0010010: w_val = 4'd2;
      7'b0000110: w_val = 4'd3;
      7'b1001100: w_val = 4'd4;
      7'b0100100: w_val = 4'd5;
      7'b0100000: w_val = 4'd6;
      7'b0001101: w_val = 4'd7;
      7'b0000000: w_val = 4'd8;
      7'b0000100: w_val = 4'd9;
      default:    w_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits     <= '0;
      r_dp         <= '0;
      r_valid      <= '0;
      r_mask       <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      if (bus.clr) begin
        r_digits     <= '0;
        r_dp         <= '0;
        r_valid      <= '0;
        r_mask       <= '0;
        r_err_sticky <= 1'b0;
      end else if (w_capture && !w_idle) begin
        if (!w_onehot) begin
          r_err        <= 1'b1;
          r_err_sticky <= 1'b1;
        end else begin
          if (w_known) begin
            r_digits[w_idx] <= w_val;
            r_valid[w_idx]  <= 1'b1;
            r_dp[w_idx]     <= ~r_data_s2[0];
          end else begin
            r_valid[w_idx] <= 1'b0;
            if (w_blank) begin
              r_dp[w_idx] <= ~r_data_s2[0];
            end else begin
              r_err        <= 1'b1;
              r_err_sticky <= 1'b1;
            end
          end
          // Completing the mask starts the next frame in the same update.
          if (w_mask_next == ALL_SEEN) begin
            r_frame_done <= 1'b1;
            r_mask       <= '0;
          end else begin
            r_mask <= w_mask_next;
          end
        end
      end
    end
  end

  assign bus.digits      = r_digits;
  assign bus.dp_flags    = r_dp;
  assign bus.digit_valid = r_valid;
  assign bus.frame_done  = r_frame_done;
  assign bus.err         = r_err;
  assign bus.err_sticky  = r_err_sticky;
endmodule
